mem_reader: RTL
===============

MEM_READER -- requirements
Module: mem_reader

Interface
REQ-001 SHALL have no parameters; address width fixed at 24, data width at 32.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request strobe; sampled only when busy=0.
REQ-005 address  input  24  byte address of the least-significant byte.
REQ-006 size  input  2  0=1 byte, 1=2 bytes, 2=3 bytes, 3=4 bytes.
REQ-007 busy  output  1  high while a request is in progress.
REQ-008 done  output  1  one-cycle pulse: data_out valid.
REQ-009 data_out  output  32  assembled little-endian value, zero-extended.
REQ-010 mem_address  output  24  byte address to the memory; registered.
REQ-011 mem_data_in  input  8  byte from memory, valid one clock after its address is presented.

Function
REQ-012 SHALL assume byte memory with exactly one cycle of registered read latency: the address presented in cycle k yields its data in cycle k+1.
REQ-013 States SHALL be IDLE, READ and DONE; reset enters IDLE.
REQ-014 IDLE: start=1 at edge E0 SHALL latch the address and size, set mem_address=address, clear data_out, set busy=1 and enter READ.
REQ-015 READ SHALL advance mem_address by 1 each cycle until the last byte address has been presented, then hold it.
REQ-016 READ SHALL capture byte i (i=0..n-1, n=size+1) at edge E(i+2) into data_out[8i+7:8i].
REQ-017 The capture at E(n+1) SHALL enter DONE; DONE lasts one cycle with done=1 and busy=0, then returns to IDLE.
REQ-018 For any request, latency from the start edge to done high SHALL be n+1 clocks; e.g. size=3 gives done visible after E5.
REQ-019 start=1 during DONE SHALL be accepted exactly as in IDLE (back-to-back); the DONE cycle still shows done=1.
REQ-020 start while busy=1 SHALL be ignored, and the latched address and size SHALL not change.
REQ-021 data_out bytes at or above n SHALL be zero; data_out SHALL hold its value after DONE until the next accepted start.
REQ-022 Address increment SHALL be modulo 2^24 (0xFFFFFF+1=0x000000) unless REQ-027 applies.

Reset
REQ-023 On reset=1 at a rising edge, the block SHALL enter IDLE with busy=0, done=0, data_out=0 and mem_address=0, regardless of state.
REQ-024 Reset mid-request SHALL abort the request with no done pulse; start on the first edge after reset deasserts SHALL be accepted.
REQ-025 Memory contents SHALL NOT be affected; the block has no write path.

Configuration
REQ-026 The macro MEM_READER_BANK_WRAP_EN SHALL select address-increment behaviour at compile time.
REQ-027 With the macro defined, only mem_address[15:0] SHALL increment (0x12FFFF+1=0x120000), matching 65xx bank wrap; without it, REQ-022 applies.

Structure
REQ-028 A shared package SHALL hold the state enumeration, the size encodings and the constants ADDR_WIDTH=24 and DATA_WIDTH=32.
REQ-029 The design SHALL be a single module with no sub-module; the address incrementer SHALL be inline logic selected by the macro.

Verification
REQ-030 Memory model with 1-cycle latency, mem[0x000100..0x000103]=11,22,33,44; start, address=0x000100, size=3 -> done after 4+1 clocks, data_out=0x44332211.
REQ-031 Same memory, size=0 at 0x000102 -> done two clocks after start, data_out=0x00000033; size=2 -> 0x00332211.
REQ-032 Back-to-back: start size=1 at 0x000100, then start again in the DONE cycle at 0x000102 -> 0x00002211, then 0x00004433, with no idle cycle between.
REQ-033 Reset asserted one clock after a size=3 start -> busy=0, mem_address=0, no done pulse; a new request then completes normally.
REQ-034 Address 0x00FFFF, size=1 -> second mem_address is 0x010000 without the macro and 0x000000 with MEM_READER_BANK_WRAP_EN.
REQ-035 start held high while busy -> exactly one done per accepted request, with latched address and size unchanged.

Source files
------------

// File: rtl/mem_reader_pkg.sv
// Shared definitions for the byte-serial memory reader.
// Holds the FSM state encoding, the request size encodings and the fixed
// address/data widths used by mem_reader.
package mem_reader_pkg;

    localparam int ADDR_WIDTH = 24;
    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // size field: number of bytes minus one
    localparam logic [1:0] SIZE_1B = 2'd0;
    localparam logic [1:0] SIZE_2B = 2'd1;
    localparam logic [1:0] SIZE_3B = 2'd2;
    localparam logic [1:0] SIZE_4B = 2'd3;

endpackage

// File: rtl/mem_reader.sv
// Purpose : reads 1..4 consecutive bytes from a 1-cycle-latency byte memory
//           and assembles them little-endian, zero-extended, into data_out.
// Latency : done pulses n+1 clocks after the accepting start edge (n = size+1).
// Backpr. : start is sampled only while not busy (IDLE or DONE); requests
//           arriving during READ are dropped, latched request is unaffected.
// Build   : define MEM_READER_BANK_WRAP_EN to wrap increments inside the
//           64 KiB bank (only mem_address[15:0] counts); otherwise 24-bit wrap.
// Ports   : clk, reset (sync, active-high); start/address/size request;
//           busy, done, data_out status/result; mem_address/mem_data_in
//           memory read port.
module mem_reader
    import mem_reader_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [1:0]            size,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [7:0]            mem_data_in
);

    state_e                  state_q;
    logic                    busy_q;
    logic                    done_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_d;
    logic [1:0]              size_q;
    // cycles spent in READ; byte (cyc_q-1) arrives on the edge ending cycle cyc_q
    logic [2:0]              cyc_q;
    logic [1:0]              byte_idx;

    always_comb begin
        mem_addr_d = mem_addr_q;
`ifdef MEM_READER_BANK_WRAP_EN
        mem_addr_d = {mem_addr_q[23:16], mem_addr_q[15:0] + 16'd1};
`else
        mem_addr_d = mem_addr_q + 24'd1;
`endif
    end

    // cyc_q==4 wraps to index 3, which is the last byte of a 4-byte read
    assign byte_idx = cyc_q[1:0] - 2'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            data_q     <= '0;
            mem_addr_q <= '0;
            size_q     <= SIZE_1B;
            cyc_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                    if (start) begin
                        size_q     <= size;
                        mem_addr_q <= address;
                        data_q     <= '0;
                        cyc_q      <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_READ;
                    end
                end
                ST_READ: begin
                    cyc_q <= cyc_q + 3'd1;
                    // keep presenting new addresses until the last byte's is out
                    if (cyc_q < {1'b0, size_q}) begin
                        mem_addr_q <= mem_addr_d;
                    end
                    if (cyc_q != 3'd0) begin
                        data_q[{byte_idx, 3'b000} +: 8] <= mem_data_in;
                        if (byte_idx == size_q) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign data_out    = data_q;
    assign mem_address = mem_addr_q;

endmodule
